// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Load/store port between the core memory stage (master) and the data
//   memory responder (slave).
//   Request channel : req_valid/req_ready handshake carrying we, byte address,
//                     right-aligned store data and the funct3 access size.
//   Response channel: rsp_valid/rsp_ready handshake carrying extended load
//                     data and an access-fault flag.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_mask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_mask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the core load/store port. Accepts one request
//   at a time, waits WAIT_STATES cycles, performs a byte/halfword/word access
//   (RISC-V funct3 sizes, sign/zero-extended loads) on an internal array and
//   returns data plus an error flag.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - synchronous, active-low
//   bus   - dmem_responder_if.slave (request and response channels)
// Parameters:
//   DEPTH_WORDS - 32-bit words in the array
//   WAIT_STATES - extra cycles between acceptance and access (0..15)
//   BASE_ADDR   - byte address of word 0
// Build option:
//   DMEM_MISALIGN_TRAP_EN - when defined, misaligned H/HU/W accesses fault;
//   otherwise they are force-aligned without error.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ACCESS, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  mask_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        accept;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] offs;
  logic [AW-1:0] idx;
  logic        range_err, mask_err, mis_err, fault;
  logic [1:0]  lane;
  logic [3:0]  be;
  logic [31:0] wd, word, shifted, ld;
  logic        mem_we;

  // Access decode works only on the latched request copy.
  always_comb begin
    offs      = addr_q - BASE_ADDR;
    idx       = offs[AW+1:2];
    range_err = (addr_q < BASE_ADDR) || ((offs >> 2) >= DEPTH_WORDS);

    case (mask_q)
      3'b000, 3'b001, 3'b010: mask_err = 1'b0;
      3'b100, 3'b101:         mask_err = we_q;
      default:                mask_err = 1'b1;
    endcase

    // Lane is force-aligned for H/W; in trap builds a misaligned access
    // faults before the aligned lane could matter.
    lane = addr_q[1:0];
    be   = '0;
    wd   = wdata_q;
    case (mask_q[1:0])
      2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane = {addr_q[1], 1'b0};
        be   = 4'b0011 << lane;
        wd   = {2{wdata_q[15:0]}};
      end
      default: begin
        lane = 2'b00;
        be   = '1;
      end
    endcase

`ifdef DMEM_MISALIGN_TRAP_EN
    mis_err = ((mask_q[1:0] == 2'b01) && addr_q[0]) ||
              ((mask_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
    mis_err = 1'b0;
`endif

    fault   = range_err | mask_err | mis_err;
    word    = mem[idx];
    shifted = word >> {lane, 3'b000};

    case (mask_q)
      3'b000:  ld = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld = {24'h0, shifted[7:0]};
      3'b001:  ld = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ld = {16'h0, shifted[15:0]};
      default: ld = shifted;
    endcase

    // A store in ACCESS is dropped if reset is sampled on the same edge.
    mem_we = (state_q == ACCESS) && reset && we_q && !fault;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? ACCESS : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q <= 4'd1) state_d = ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ACCESS: begin
        rdata_d = (fault || we_q) ? '0 : ld;
        err_d   = fault;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        mask_q  <= bus.req_mask;
      end
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Scoreboard bench for dmem_responder (WAIT_STATES=2, DEPTH_WORDS=1024).
//   The driver pushes the hand-computed response of each request into a
//   queue; a negedge monitor pops and compares on every response handshake,
//   and also checks latency, stall stability and req_ready reassertion.
module tb_dmem_responder;
  localparam int unsigned WS    = 2;
  localparam int unsigned DEPTH = 1024;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam logic [31:0] M10 = 32'hBEEF3344;
`else
  localparam logic [31:0] M10 = 32'hBEEF1234;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(WS),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   last_hs_edge = -10;
  int   next_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Monitor / scoreboard
  logic        prev_valid = 1'b0;
  logic        prev_stall = 1'b0;
  logic        hs_pending = 1'b0;
  logic [31:0] prev_rdata = '0;
  logic        prev_err   = 1'b0;
  int          first_valid_edge = 0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
      hs_pending = 1'b0;
    end else begin
      if (hs_pending && cyc == last_hs_edge) begin
        chk("req_ready_after_rsp", {31'b0, bus.req_ready}, 32'd1);
        hs_pending = 1'b0;
      end
      if (bus.req_valid && bus.req_ready) acc_q.push_back(cyc + 1);
      if (bus.rsp_valid) begin
        if (!prev_valid) first_valid_edge = cyc + 1;
        if (prev_stall) begin
          chk("stall_rdata_stable", bus.rsp_rdata, prev_rdata);
          chk("stall_err_stable", {31'b0, bus.rsp_err}, {31'b0, prev_err});
          chk("stall_req_ready_low", {31'b0, bus.req_ready}, 32'd0);
        end
        if (bus.rsp_ready) begin
          if (exp_q.size() == 0 || acc_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rdata %h err %b, expected none", bus.rsp_rdata, bus.rsp_err);
          end else begin
            exp_t e;
            int   a;
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            chk($sformatf("rdata[%0d]", e.id), bus.rsp_rdata, e.rdata);
            chk($sformatf("err[%0d]", e.id), {31'b0, bus.rsp_err}, {31'b0, e.err});
            chk($sformatf("latency[%0d]", e.id), 32'(first_valid_edge - a), 32'(2 + WS));
          end
          last_hs_edge = cyc + 1;
          hs_pending   = 1'b1;
        end
        prev_stall = !bus.rsp_ready;
        prev_rdata = bus.rsp_rdata;
        prev_err   = bus.rsp_err;
      end else begin
        prev_stall = 1'b0;
      end
      prev_valid = bus.rsp_valid;
    end
  end

  // Driver
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] m);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_mask  = m;
  endtask

  task automatic expect_rsp(input logic [31:0] rd, input logic err);
    exp_t e;
    e.rdata = rd;
    e.err   = err;
    e.id    = next_id;
    next_id++;
    exp_q.push_back(e);
  endtask

  // Returns the edge at which the request is accepted; leaves time just after it.
  task automatic wait_accept(output int e);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("accept");
    e = cyc + 1;
    tick();
  endtask

  // Garbage on the request bus after acceptance must not affect the access.
  task automatic scramble();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_mask  = 3'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout("drain");
    tick();
  endtask

  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] m, input logic [31:0] rd, input logic err);
    int e;
    expect_rsp(rd, err);
    drive_req(we, a, wd, m);
    wait_accept(e);
    scramble();
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1, e2;
    int n;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_mask  = '0;
    bus.rsp_ready = 1'b1;
    reset = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("reset_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Word store / load
    xact(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
    xact(1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0);

    // Byte lanes and extension
    xact(1'b1, 32'h10, 32'h11223344, 3'b010, 32'h0, 1'b0);
    xact(1'b1, 32'h13, 32'hAAAAAA80, 3'b000, 32'h0, 1'b0);
    xact(1'b0, 32'h10, 32'h0, 3'b010, 32'h80223344, 1'b0);
    xact(1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0);
    xact(1'b0, 32'h13, 32'h0, 3'b100, 32'h00000080, 1'b0);

    // Halfword lanes and extension
    xact(1'b1, 32'h12, 32'h5555BEEF, 3'b001, 32'h0, 1'b0);
    xact(1'b0, 32'h12, 32'h0, 3'b101, 32'h0000BEEF, 1'b0);
    xact(1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFFBEEF, 1'b0);
    xact(1'b0, 32'h10, 32'h0, 3'b010, 32'hBEEF3344, 1'b0);
    xact(1'b0, 32'h10, 32'h0, 3'b000, 32'h00000044, 1'b0);
    xact(1'b0, 32'h10, 32'h0, 3'b001, 32'h00003344, 1'b0);
    xact(1'b0, 32'h11, 32'h0, 3'b000, 32'h00000033, 1'b0);

    // Errors: out of range, illegal masks; target word must be unchanged
    xact(1'b0, DEPTH * 4, 32'h0, 3'b010, 32'h0, 1'b1);
    xact(1'b1, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1);
    xact(1'b1, 32'h10, 32'h0, 3'b100, 32'h0, 1'b1);
    xact(1'b0, 32'h10, 32'h0, 3'b111, 32'h0, 1'b1);
    xact(1'b0, 32'h10, 32'h0, 3'b010, 32'hBEEF3344, 1'b0);

    // Last word in range
    xact(1'b1, DEPTH * 4 - 4, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0);
    xact(1'b0, DEPTH * 4 - 4, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0);

    // Misalignment
`ifdef DMEM_MISALIGN_TRAP_EN
    xact(1'b0, 32'h11, 32'h0, 3'b010, 32'h0, 1'b1);
    xact(1'b0, 32'h13, 32'h0, 3'b001, 32'h0, 1'b1);
    xact(1'b1, 32'h11, 32'h00001234, 3'b001, 32'h0, 1'b1);
`else
    xact(1'b0, 32'h11, 32'h0, 3'b010, 32'hBEEF3344, 1'b0);
    xact(1'b0, 32'h13, 32'h0, 3'b001, 32'hFFFFBEEF, 1'b0);
    xact(1'b1, 32'h11, 32'h00001234, 3'b001, 32'h0, 1'b0);
`endif
    xact(1'b0, 32'h10, 32'h0, 3'b010, M10, 1'b0);

    // Back-pressure with a request raised during the stall
    bus.rsp_ready = 1'b0;
    expect_rsp(M10, 1'b0);
    drive_req(1'b0, 32'h10, 32'h0, 3'b010);
    wait_accept(e0);
    scramble();
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout("stall_rsp_valid");
    tick();
    expect_rsp(32'h000000EF, 1'b0);
    drive_req(1'b0, 32'h12, 32'h0, 3'b100);
    repeat (5) tick();
    bus.rsp_ready = 1'b1;
    wait_accept(e1);
    chk("deferred_accept_edge", 32'(e1), 32'(last_hs_edge + 1));
    scramble();
    drain();

    // Back-to-back throughput
    expect_rsp(M10, 1'b0);
    expect_rsp(32'h000000BE, 1'b0);
    expect_rsp(32'h0000BEEF, 1'b0);
    drive_req(1'b0, 32'h10, 32'h0, 3'b010);
    wait_accept(e0);
    drive_req(1'b0, 32'h13, 32'h0, 3'b100);
    wait_accept(e1);
    drive_req(1'b0, 32'h12, 32'h0, 3'b101);
    wait_accept(e2);
    scramble();
    drain();
    chk("throughput_1", 32'(e1 - e0), 32'(3 + WS));
    chk("throughput_2", 32'(e2 - e1), 32'(3 + WS));

    // Reset abort during BUSY drops the store
    xact(1'b1, 32'h20, 32'h0, 3'b010, 32'h0, 1'b0);
    drive_req(1'b1, 32'h20, 32'h12345678, 3'b010);
    wait_accept(e0);
    scramble();
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("abort_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("abort_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    exp_q.delete();
    acc_q.delete();
    tick();
    reset = 1'b1;
    tick();
    xact(1'b0, 32'h20, 32'h0, 3'b010, 32'h0, 1'b0);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
